// File: rtl/frag_queue_reassembly.sv
// Fragment reassembly queue for the last-node path.
// Stores fragment descriptors into per-flow queue slots chosen by the flow-table lookup.
// When a flow's last fragment arrives, its queue is drained in fragment order, the
// flow-table entry is invalidated, and the queue is handed back to the free pool.
module frag_queue_reassembly #(
  parameter int unsigned DESC_W     = 16,
  parameter int unsigned PEND_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DESC_W-1:0] iv_desc,
  input  logic              i_desc_wr,
  input  logic [4:0]        iv_queue_id,
  input  logic [3:0]        iv_queue_usedw,
  input  logic              i_queue_id_wr,
  input  logic              i_all_queue_used,
  input  logic              i_last_frag_flag,
  output logic [31:0]       ov_queue_empty,
  output logic [DESC_W-1:0] ov_pkt_desc,
  output logic              o_pkt_desc_valid,
  output logic              o_pkt_desc_last,
  input  logic              i_pkt_desc_ready,
  output logic [4:0]        ov_free_ram_waddr,
  output logic [18:0]       ov_free_ram_wdata,
  output logic              o_free_ram_wr,
  output logic [DESC_W-1:0] ov_discard_desc,
  output logic              o_discard_desc_wr,
  output logic              o_pend_overflow_pulse
);

  localparam int unsigned PAW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;
  localparam logic [1:0] ST_FREE = 2'd3;

  // Descriptor captured at lookup start, consumed when the lookup result arrives.
  logic [DESC_W-1:0] rv_desc;

  // Descriptor storage, addressed {queue_id, slot}; not reset.
  logic [DESC_W-1:0] desc_mem [512];
  logic [DESC_W-1:0] rd_data_q;

  // Pending-drain FIFO entries: {queue_id, fragment count}.
  logic [9:0]   pend_mem [PEND_DEPTH];
  logic [PAW:0] wr_ptr_q, rd_ptr_q;
  logic         pend_empty, pend_full;
  logic         last_in, push, pop;
  logic [4:0]   cnt_in;

  logic [1:0]   state_q, state_d;
  logic [4:0]   rq_q;
  logic [4:0]   rcnt_q;
  logic [3:0]   idx_q;
  logic         desc_last;
  logic         accept;

  logic [31:0]       empty_q, empty_d;
  logic [31:0]       set_mask, clr_mask;
  logic [DESC_W-1:0] discard_desc_q;
  logic              discard_wr_q;
  logic              ovf_q;

  assign pend_empty = (wr_ptr_q == rd_ptr_q);
  assign pend_full  = (wr_ptr_q[PAW] != rd_ptr_q[PAW]) &&
                      (wr_ptr_q[PAW-1:0] == rd_ptr_q[PAW-1:0]);
  assign last_in    = i_queue_id_wr & i_last_frag_flag;
  assign push       = last_in & ~pend_full;
  assign pop        = (state_q == ST_IDLE) & ~pend_empty;
  assign cnt_in     = {1'b0, iv_queue_usedw} + 5'd1;

  assign desc_last  = ({1'b0, idx_q} == (rcnt_q - 5'd1));
  assign accept     = (state_q == ST_OUT) & i_pkt_desc_ready;

  // Capture the descriptor of the fragment under lookup.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rv_desc <= '0;
    end else if (i_desc_wr) begin
      rv_desc <= iv_desc;
    end
  end

  // Storage write port: one write per successful lookup.
  always_ff @(posedge i_clk) begin
    if (i_queue_id_wr) begin
      desc_mem[{iv_queue_id, iv_queue_usedw}] <= rv_desc;
    end
  end

  // Registered read port, loaded in the RD state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else if (state_q == ST_RD) begin
      rd_data_q <= desc_mem[{rq_q, idx_q}];
    end
  end

  // Pending FIFO storage; contents need no reset since pointers gate them.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pend_mem[wr_ptr_q[PAW-1:0]] <= {iv_queue_id, cnt_in};
    end
  end

  // Pending FIFO pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Drain FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!pend_empty) state_d = ST_RD;
      ST_RD:   state_d = ST_OUT;
      ST_OUT:  if (i_pkt_desc_ready) state_d = desc_last ? ST_FREE : ST_RD;
      ST_FREE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Drain FSM state plus the active queue, its length and the current slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      rq_q    <= '0;
      rcnt_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        rq_q   <= pend_mem[rd_ptr_q[PAW-1:0]][9:5];
        rcnt_q <= pend_mem[rd_ptr_q[PAW-1:0]][4:0];
        idx_q  <= '0;
      end else if (accept && !desc_last) begin
        idx_q  <= idx_q + 4'd1;
      end
    end
  end

  // Queue-empty bitmap: set on free, clear on last fragment. The lookup never
  // picks a queue whose bit is 0, so set and clear never hit the same bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (state_q == ST_FREE) set_mask = 32'd1 << rq_q;
    if (last_in)            clr_mask = 32'd1 << iv_queue_id;
    empty_d = (empty_q | set_mask) & ~clr_mask;
  end

  // Bitmap, discard and overflow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      empty_q        <= '1;
      discard_desc_q <= '0;
      discard_wr_q   <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      empty_q      <= empty_d;
      discard_wr_q <= i_all_queue_used;
      ovf_q        <= last_in & pend_full;
      if (i_all_queue_used) discard_desc_q <= rv_desc;
    end
  end

  assign ov_queue_empty        = empty_q;
  assign o_pkt_desc_valid      = (state_q == ST_OUT);
  assign ov_pkt_desc           = o_pkt_desc_valid ? rd_data_q : '0;
  assign o_pkt_desc_last       = o_pkt_desc_valid & desc_last;
  assign o_free_ram_wr         = (state_q == ST_FREE);
  assign ov_free_ram_waddr     = o_free_ram_wr ? rq_q : 5'd0;
  assign ov_free_ram_wdata     = '0;
  assign ov_discard_desc       = discard_desc_q;
  assign o_discard_desc_wr     = discard_wr_q;
  assign o_pend_overflow_pulse = ovf_q;

endmodule

// File: tb/tb_frag_queue_reassembly.sv
// Scoreboard bench for frag_queue_reassembly: stimulus pushes expected drain,
// free and discard events; a negedge monitor pops and compares them.
module tb_frag_queue_reassembly;

  localparam int unsigned DESC_W = 16;

  logic              i_clk;
  logic              i_rst_n;
  logic [DESC_W-1:0] iv_desc;
  logic              i_desc_wr;
  logic [4:0]        iv_queue_id;
  logic [3:0]        iv_queue_usedw;
  logic              i_queue_id_wr;
  logic              i_all_queue_used;
  logic              i_last_frag_flag;
  logic [31:0]       ov_queue_empty;
  logic [DESC_W-1:0] ov_pkt_desc;
  logic              o_pkt_desc_valid;
  logic              o_pkt_desc_last;
  logic              i_pkt_desc_ready;
  logic [4:0]        ov_free_ram_waddr;
  logic [18:0]       ov_free_ram_wdata;
  logic              o_free_ram_wr;
  logic [DESC_W-1:0] ov_discard_desc;
  logic              o_discard_desc_wr;
  logic              o_pend_overflow_pulse;

  frag_queue_reassembly #(.DESC_W(DESC_W), .PEND_DEPTH(4)) dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .iv_desc               (iv_desc),
    .i_desc_wr             (i_desc_wr),
    .iv_queue_id           (iv_queue_id),
    .iv_queue_usedw        (iv_queue_usedw),
    .i_queue_id_wr         (i_queue_id_wr),
    .i_all_queue_used      (i_all_queue_used),
    .i_last_frag_flag      (i_last_frag_flag),
    .ov_queue_empty        (ov_queue_empty),
    .ov_pkt_desc           (ov_pkt_desc),
    .o_pkt_desc_valid      (o_pkt_desc_valid),
    .o_pkt_desc_last       (o_pkt_desc_last),
    .i_pkt_desc_ready      (i_pkt_desc_ready),
    .ov_free_ram_waddr     (ov_free_ram_waddr),
    .ov_free_ram_wdata     (ov_free_ram_wdata),
    .o_free_ram_wr         (o_free_ram_wr),
    .ov_discard_desc       (ov_discard_desc),
    .o_discard_desc_wr     (o_discard_desc_wr),
    .o_pend_overflow_pulse (o_pend_overflow_pulse)
  );

  typedef struct packed {
    logic [DESC_W-1:0] d;
    logic              last;
  } pkt_t;

  pkt_t              exp_pkt[$];
  logic [4:0]        exp_free[$];
  logic [DESC_W-1:0] exp_disc[$];

  int checks = 0;
  int fails  = 0;
  int ovf_seen = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One fragment: descriptor strobe, then the lookup result strobe.
  task automatic send_frag(input logic [DESC_W-1:0] d, input logic [4:0] q,
                           input logic [3:0] u, input logic last);
    iv_desc = d;
    i_desc_wr = 1'b1;
    tick(1);
    i_desc_wr = 1'b0;
    iv_queue_id = q;
    iv_queue_usedw = u;
    i_last_frag_flag = last;
    i_queue_id_wr = 1'b1;
    tick(1);
    i_queue_id_wr = 1'b0;
    i_last_frag_flag = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_pkt.size() != 0 || exp_free.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_pending_left", exp_pkt.size() + exp_free.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    logic              pv, pr;
    logic [DESC_W-1:0] pd;
    pkt_t              e;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        chk("hold_valid", o_pkt_desc_valid, 1);
        chk("hold_desc", ov_pkt_desc, pd);
      end
      if (o_pkt_desc_valid && i_pkt_desc_ready) begin
        if (exp_pkt.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pkt: got desc %h, expected no output", ov_pkt_desc);
        end else begin
          e = exp_pkt.pop_front();
          chk("pkt_desc", ov_pkt_desc, e.d);
          chk("pkt_last", o_pkt_desc_last, e.last);
        end
      end
      if (o_free_ram_wr) begin
        if (exp_free.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_free: got waddr %0d, expected no write", ov_free_ram_waddr);
        end else begin
          chk("free_waddr", ov_free_ram_waddr, exp_free.pop_front());
          chk("free_wdata", ov_free_ram_wdata, 0);
        end
      end
      if (o_discard_desc_wr) begin
        if (exp_disc.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_discard: got %h, expected no strobe", ov_discard_desc);
        end else begin
          chk("discard_desc", ov_discard_desc, exp_disc.pop_front());
        end
      end
      if (o_pend_overflow_pulse) ovf_seen++;
      pv = o_pkt_desc_valid;
      pr = i_pkt_desc_ready;
      pd = ov_pkt_desc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst_n = 1'b0;
    iv_desc = '0;
    i_desc_wr = 1'b0;
    iv_queue_id = '0;
    iv_queue_usedw = '0;
    i_queue_id_wr = 1'b0;
    i_all_queue_used = 1'b0;
    i_last_frag_flag = 1'b0;
    i_pkt_desc_ready = 1'b1;
    tick(2);

    // Reset state
    chk("rst_empty", ov_queue_empty, 32'hFFFF_FFFF);
    chk("rst_valid", o_pkt_desc_valid, 0);
    chk("rst_free_wr", o_free_ram_wr, 0);
    chk("rst_discard_wr", o_discard_desc_wr, 0);
    chk("rst_ovf", o_pend_overflow_pulse, 0);
    i_rst_n = 1'b1;
    tick(1);

    // Three fragments on queue 5
    exp_pkt.push_back('{d: 16'h1111, last: 1'b0});
    exp_pkt.push_back('{d: 16'h2222, last: 1'b0});
    exp_pkt.push_back('{d: 16'h3333, last: 1'b1});
    exp_free.push_back(5'd5);
    send_frag(16'h1111, 5'd5, 4'd0, 1'b0);
    send_frag(16'h2222, 5'd5, 4'd1, 1'b0);
    chk("q5_bit_before_last", ov_queue_empty[5], 1);
    send_frag(16'h3333, 5'd5, 4'd2, 1'b1);
    chk("q5_bit_cleared", ov_queue_empty[5], 0);
    wait_drain(100);
    tick(2);
    chk("q5_freed", ov_queue_empty, 32'hFFFF_FFFF);

    // Single fragment on queue 31 with ready held low
    i_pkt_desc_ready = 1'b0;
    exp_pkt.push_back('{d: 16'hA5A5, last: 1'b1});
    exp_free.push_back(5'd31);
    send_frag(16'hA5A5, 5'd31, 4'd0, 1'b1);
    tick(10);
    chk("q31_valid_held", o_pkt_desc_valid, 1);
    chk("q31_desc_held", ov_pkt_desc, 16'hA5A5);
    chk("q31_bit_cleared", ov_queue_empty[31], 0);
    i_pkt_desc_ready = 1'b1;
    wait_drain(100);
    tick(2);
    chk("q31_freed", ov_queue_empty, 32'hFFFF_FFFF);

    // 16-fragment packet on queue 0
    for (int i = 0; i < 16; i++) begin
      exp_pkt.push_back('{d: 16'h1000 + 16'(i), last: (i == 15)});
    end
    exp_free.push_back(5'd0);
    for (int i = 0; i < 16; i++) begin
      send_frag(16'h1000 + 16'(i), 5'd0, 4'(i), (i == 15));
    end
    wait_drain(200);
    tick(2);
    chk("q0_freed", ov_queue_empty, 32'hFFFF_FFFF);

    // Lookup failure: discard must not touch storage slot {9,0}
    send_frag(16'h9999, 5'd9, 4'd0, 1'b0);
    iv_desc = 16'hBEEF;
    i_desc_wr = 1'b1;
    tick(1);
    i_desc_wr = 1'b0;
    exp_disc.push_back(16'hBEEF);
    iv_queue_id = 5'd9;
    iv_queue_usedw = 4'd0;
    i_all_queue_used = 1'b1;
    tick(1);
    i_all_queue_used = 1'b0;
    chk("discard_strobe", o_discard_desc_wr, 1);
    chk("discard_value", ov_discard_desc, 16'hBEEF);
    tick(1);
    chk("discard_one_cycle", o_discard_desc_wr, 0);
    chk("discard_bitmap", ov_queue_empty, 32'hFFFF_FFFF);
    exp_pkt.push_back('{d: 16'h9999, last: 1'b0});
    exp_pkt.push_back('{d: 16'h9A9A, last: 1'b1});
    exp_free.push_back(5'd9);
    send_frag(16'h9A9A, 5'd9, 4'd1, 1'b1);
    wait_drain(100);
    chk("discard_queue_empty", exp_disc.size(), 0);

    // Overflow: queue 6 stalls in OUT so queues 1-4 fill the pending FIFO
    i_pkt_desc_ready = 1'b0;
    exp_pkt.push_back('{d: 16'h6666, last: 1'b1});
    exp_free.push_back(5'd6);
    send_frag(16'h6666, 5'd6, 4'd0, 1'b1);
    for (int q = 1; q <= 5; q++) begin
      if (q <= 4) begin
        exp_pkt.push_back('{d: 16'hC000 + 16'(q), last: 1'b1});
        exp_free.push_back(5'(q));
      end
      send_frag(16'hC000 + 16'(q), 5'(q), 4'd0, 1'b1);
      chk("ovf_pulse", o_pend_overflow_pulse, (q == 5));
    end
    tick(1);
    chk("ovf_one_cycle", o_pend_overflow_pulse, 0);
    chk("ovf_bits_clear", ov_queue_empty & 32'h0000_007E, 0);
    i_pkt_desc_ready = 1'b1;
    wait_drain(300);
    tick(2);
    chk("ovf_q5_stays_used", ov_queue_empty, 32'hFFFF_FFDF);

    // Reset while queue 7 is presented in OUT
    i_pkt_desc_ready = 1'b0;
    send_frag(16'h7777, 5'd7, 4'd0, 1'b1);
    n = 0;
    while (!o_pkt_desc_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("q7_reached_out", o_pkt_desc_valid, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", o_pkt_desc_valid, 0);
    chk("midrst_desc", ov_pkt_desc, 0);
    chk("midrst_last", o_pkt_desc_last, 0);
    chk("midrst_free_wr", o_free_ram_wr, 0);
    chk("midrst_waddr", ov_free_ram_waddr, 0);
    chk("midrst_empty", ov_queue_empty, 32'hFFFF_FFFF);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_pkt_desc_ready = 1'b1;
    tick(10);
    chk("postrst_empty", ov_queue_empty, 32'hFFFF_FFFF);
    chk("postrst_valid", o_pkt_desc_valid, 0);
    chk("ovf_total", ovf_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
